// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the mem_responder memory/IO responder.
package mem_responder_pkg;

  localparam logic [1:0]  IO_WINDOW_SEL = 2'b11;
  localparam logic [31:0] IO_TX_ADDR    = 32'h0003_0000;
  localparam logic [31:0] IO_STAT_ADDR  = 32'h0003_0004;
  localparam logic [7:0]  ZERO_BYTE     = 8'h00;

  // Address bits that take part in IO decode; everything above is ignored.
  localparam int IO_DEC_W = 18;

  // Which source drives mem_din after the most recent read.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_IO   = 2'd2
  } rd_src_e;

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// Byte-wide synchronous FIFO with power-of-two depth and a one-bit-wider count.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  // A pop on an empty FIFO is a no-op; a push on a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : storage[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by the pointers, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide RAM responder with a memory-mapped TX FIFO window at 0x3xxxx.
// Optional macro MEM_RESPONDER_WRITE_PROTECT_EN discards RAM writes below PROTECT_LIMIT.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          RAM_ADDR_W    = 17,
  parameter int          FIFO_DEPTH    = 16,
  parameter string       INIT_FILE     = "",
  parameter logic [31:0] PROTECT_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        io_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]            ram [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  is_io;
  logic                  io_wr;
  logic                  io_wr_tx;
  logic                  io_wr_stat;
  logic                  wp_fault;
  logic                  ram_we;
  logic [7:0]            io_rdata;
  logic [7:0]            ram_q;
  logic [7:0]            io_q;
  rd_src_e               rd_src;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop_fire;
  logic [CNT_W-1:0]      fifo_count;
  logic                  unused_bits;

  assign ram_addr   = mem_a[RAM_ADDR_W-1:0];
  assign is_io      = (mem_a[17:16] == IO_WINDOW_SEL);
  assign io_wr      = mem_wr && is_io && rdy;
  assign io_wr_tx   = io_wr && (mem_a[IO_DEC_W-1:0] == IO_TX_ADDR[IO_DEC_W-1:0]);
  assign io_wr_stat = io_wr && (mem_a[IO_DEC_W-1:0] == IO_STAT_ADDR[IO_DEC_W-1:0]);
  assign tx_valid   = !fifo_empty;
  assign pop_fire   = tx_valid && tx_ready;

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
  assign wp_fault    = mem_wr && !is_io &&
                       ({{(32-RAM_ADDR_W){1'b0}}, ram_addr} < PROTECT_LIMIT);
  assign unused_bits = ^{mem_a[31:IO_DEC_W], fifo_count};
`else
  assign wp_fault    = 1'b0;
  assign unused_bits = ^{mem_a[31:IO_DEC_W], fifo_count, PROTECT_LIMIT};
`endif

  assign ram_we = mem_wr && !is_io && !wp_fault;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= mem_dout;
  end

  // RAM read register stays reset-free so it maps onto block-RAM output flops.
  always_ff @(posedge clk) begin
    if (!mem_wr) ram_q <= ram[ram_addr];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    io_rdata = ZERO_BYTE;
    if (mem_a[IO_DEC_W-1:0] == IO_STAT_ADDR[IO_DEC_W-1:0])
      io_rdata = {5'b0, io_overflow, fifo_full, fifo_empty};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_src <= SRC_ZERO;
      io_q   <= ZERO_BYTE;
    end else if (!mem_wr) begin
      rd_src <= is_io ? SRC_IO : SRC_RAM;
      io_q   <= io_rdata;
    end
  end

  always_comb begin
    mem_din = ZERO_BYTE;
    case (rd_src)
      SRC_RAM: mem_din = ram_q;
      SRC_IO:  mem_din = io_q;
      default: mem_din = ZERO_BYTE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      io_overflow <= 1'b0;
    else if ((io_wr_tx && fifo_full && !pop_fire) || wp_fault)
      io_overflow <= 1'b1;
    else if (io_wr_stat)
      io_overflow <= 1'b0;
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (io_wr_tx),
    .push_data(mem_dout),
    .pop      (pop_fire),
    .head     (tx_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

endmodule
